div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider implementing MIPS DIV and DIVU; the inverse operation of the existing combinational multiplier.
- Sits in the execute datapath. The controller pulses start, stalls on busy, and writes q to LO and r to HI when done pulses.
- Operands are latched at start, so the controller may change the register-file outputs while the divide runs.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must hold values 0..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request a divide. Sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU. Latched with start.
- dividend  input  WIDTH  numerator. Latched with start.
- divisor  input  WIDTH  denominator. Latched with start.
- busy  output  1  high while in CALC or FIX.
- done  output  1  one-cycle pulse when q and r are valid.
- q  output  WIDTH  quotient (to LO). Held until the next accepted start.
- r  output  WIDTH  remainder (to HI). Held until the next accepted start.
- div_by_zero  output  1  latched flag: the divisor was 0. Held with q and r.

Behaviour:
- Reset (synchronous): state=IDLE; busy=0, done=0, q=0, r=0, div_by_zero=0; counter and internal registers cleared.
- Reset mid-operation: aborts immediately. No done pulse is produced and results are cleared to 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch operands and sign mode, then take magnitudes.
  - If is_signed and the operand MSB is 1, the magnitude is the two's-complement negation. Otherwise the raw value is used.
  - Record neg_q = is_signed & (dividend MSB ^ divisor MSB) and neg_r = is_signed & dividend MSB.
  - Clear the partial remainder and the counter; go to CALC.
- CALC: one iteration per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1 bit subtractor.
  - If the result is non-negative, keep the difference and set quo LSB=1. Otherwise restore and set quo LSB=0.
  - Counter increments; after WIDTH iterations go to FIX.
- FIX:
  - q = neg_q ? -quo : quo; r = neg_r ? -rem : rem.
  - If the divisor is 0, override: q=all ones, r=raw latched dividend, div_by_zero=1. Otherwise div_by_zero=0.
  - Go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency:
  - The start-sampling edge is E0.
  - CALC iterations occur at edges E1..E32 and FIX at E33.
  - done is high in the cycle following E33, i.e. 34 cycles from start to the next accept opportunity.
  - Latency is fixed and independent of operand values, including zero and divide-by-zero.
- busy is high from the cycle after E0 through the FIX cycle, and low in IDLE and DONE.
- start while busy or in DONE is ignored; it is not queued.
- Back-to-back operation: start may be asserted in the first IDLE cycle after DONE.
- Signed semantics:
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Identity dividend = q*divisor + r holds for every nonzero divisor.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields q=0x80000000, r=0, div_by_zero=0, with no exception. The magnitude 2^31 fits unsigned and its negation wraps.
- Unsigned mode ignores operand MSBs for sign handling.
- All arithmetic is modulo 2^WIDTH except the trial subtract, which carries one extra bit.

Decomposition:
- Shared package div_pkg holds:
  - the state enum: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3;
  - WIDTH and the iteration count constant;
  - the DIV_BY_ZERO_Q constant (all ones).
- One sub-module, twos_neg: a combinational conditional negate (in, en -> en ? ~in+1 : in). It is instantiated four times, for the dividend/divisor magnitudes and the q/r fixup.
- The FSM, counter and shift registers stay in div_seq.

Test Plan:
- DIVU 100 / 7 -> after 34 cycles: done pulse; q=14, r=2, div_by_zero=0; busy high for exactly 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
- DIV 7 / 0xFFFFFFFE (-2) -> q=0xFFFFFFFD, r=1.
- DIV 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, no flag.
- DIVU 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- DIVU 5 / 0 -> q=0xFFFFFFFF, r=5, div_by_zero=1, same latency.
- Start while busy is ignored: start DIVU 50/5, re-pulse start with 9/3 at cycle 10 -> single done with q=10, r=0.
- Reset mid-operation: reset at cycle 15 -> q=r=0, busy=0, no done pulse; a new start then works normally.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
// Holds the FSM state encoding, default width and divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;

    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_twos_neg.sv
// twos_neg: combinational conditional two's-complement negate.
// Ports: value (in), en (negate when 1), result = en ? -value : value.
module twos_neg
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = value;
        if (en) begin
            result = ~value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for MIPS DIV / DIVU.
// Ports: clk, reset (sync, active-high), start, is_signed, dividend,
//   divisor -> busy, done (1-cycle pulse), q (LO), r (HI), div_by_zero.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(DIV_BY_ZERO_Q);

    div_state_t state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             dvs_zero;
    logic             neg_q;
    logic             neg_r;

    logic             dvd_neg_en;
    logic             dvs_neg_en;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign dvd_neg_en = is_signed & dividend[WIDTH-1];
    assign dvs_neg_en = is_signed & divisor[WIDTH-1];

    twos_neg #(.WIDTH(WIDTH)) u_dvd_mag (
        .value  (dividend),
        .en     (dvd_neg_en),
        .result (dvd_mag_in)
    );

    twos_neg #(.WIDTH(WIDTH)) u_dvs_mag (
        .value  (divisor),
        .en     (dvs_neg_en),
        .result (dvs_mag_in)
    );

    twos_neg #(.WIDTH(WIDTH)) u_q_fix (
        .value  (quo),
        .en     (neg_q),
        .result (q_fix)
    );

    twos_neg #(.WIDTH(WIDTH)) u_r_fix (
        .value  (rem),
        .en     (neg_r),
        .result (r_fix)
    );

    // One restoring step. The shifted partial remainder is WIDTH+1
    // bits; its top bit set means it already exceeds any divisor, so
    // the low WIDTH bits of the difference are the true remainder.
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   sub;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    assign sh      = {rem, quo[WIDTH-1]};
    assign sub     = {1'b0, sh[WIDTH-1:0]} - {1'b0, dvs_mag};
    assign fits    = sh[WIDTH] | ~sub[WIDTH];
    assign rem_nxt = fits ? sub[WIDTH-1:0] : sh[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            dvd_raw     <= '0;
            dvs_zero    <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_raw  <= dividend;
                        dvs_zero <= (divisor == '0);
                        neg_q    <= dvd_neg_en ^ dvs_neg_en;
                        neg_r    <= dvd_neg_en;
                        quo      <= dvd_mag_in;
                        dvs_mag  <= dvs_mag_in;
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dvs_zero) begin
                        q           <= DBZ_Q;
                        r           <= dvd_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        q           <= q_fix;
                        r           <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq.
// Random and directed DIV/DIVU against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div_by_zero;

    div_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division semantics.
    function automatic exp_t model(input bit s, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end else begin
            sa  = $signed(a);
            sb_ = $signed(b);
            e.q = 32'(sa / sb_);
            e.r = 32'(sa % sb_);
            e.z = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("q", q, e.q);
                check("r", r, e.r);
                check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
            end
        end
    end

    // Issue one divide now (caller guarantees IDLE) and follow it to
    // the first cycle after DONE. poke >= 0 re-pulses start mid-run.
    task automatic run_op(input bit s, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
        int lat;
        int bc;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        sb.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bc    = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
            if (lat == poke) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", lat, 32'd33);
        check("busy_cycles", bc, 32'd33);
        @(posedge clk);
        #1;
        check("done_pulse_width", {31'b0, done}, 32'd0);
        check("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_idle_zero();
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          dc;
        int          sel;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                     32'h7FFF_FFFF, 32'h2};

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero();

        run_op(1'b0, 32'd100, 32'd7, -1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1);
        run_op(1'b0, 32'd5, 32'd0, -1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, -1);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        dc = done_cnt;
        run_op(1'b0, 32'd50, 32'd5, 10);
        repeat (40) @(posedge clk);
        #1;
        check("single_done", done_cnt, dc + 1);

        dc        = done_cnt;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_zero();
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt, dc);
        run_op(1'b0, 32'd1000, 32'd33, -1);

        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 4));
            a   = $urandom;
            b   = $urandom;
            if (sel == 1) b = 32'($urandom_range(1, 300));
            if (sel == 2) b = 32'd0;
            if (sel == 3) begin
                a = specials[$urandom_range(0, 5)];
                b = specials[$urandom_range(0, 5)];
            end
            if (sel == 4) b = b >> $urandom_range(0, 31);
            run_op(s, a, b, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
